// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing the single-port instruction ROM between the fetch unit (id 0)
// and the debug read port (id 1); one ROM read in flight, response tagged with requester id.
module rom_fetch_arbiter #(
    parameter int ROM_DEPTH = 5,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              HSEL1,
    output logic              rd_en_rom,
    output logic [ADDR_W-1:0] address_rom,
    input  logic [DATA_W-1:0] instruction,
    output logic              busy
);

    // state   | meaning
    // IDLE    | waiting for a request; grant combinationally
    // ISSUE   | ROM select/read enable driven with latched address
    // CAPTURE | ROM output valid, registered into rsp_data
    // RESP    | response presented until rsp_ready
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [ADDR_W:0] ROM_BYTES = (ADDR_W + 1)'(ROM_DEPTH * 4);

    logic [1:0]        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              hsel_q, hsel_d;
    logic [ADDR_W-1:0] addr_rom_q, addr_rom_d;

    logic              grant_vld;
    logic              grant_id;
    logic [ADDR_W-1:0] grant_addr;
    logic              addr_bad;

    // rr_ptr only matters when both requesters are valid in the same cycle
    always_comb begin
        grant_vld  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
        grant_addr = grant_id ? req1_addr : req0_addr;
        addr_bad   = (grant_addr[1:0] != 2'b00) || ({1'b0, grant_addr} >= ROM_BYTES);
    end

    // ready is withheld while reset is asserted so no accept can be lost to the reset
    always_comb begin
        req0_ready = reset && (state_q == S_IDLE) && grant_vld && !grant_id;
        req1_ready = reset && (state_q == S_IDLE) && grant_vld &&  grant_id;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        hsel_d      = 1'b0;
        addr_rom_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    rsp_id_d = grant_id;
                    rr_ptr_d = ~grant_id;
                    if (addr_bad) begin
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        hsel_d     = 1'b1;
                        addr_rom_d = grant_addr;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_data_d  = instruction;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            hsel_q      <= 1'b0;
            addr_rom_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            hsel_q      <= hsel_d;
            addr_rom_q  <= addr_rom_d;
        end
    end

    // select and read enable share one flop: they are only ever high together in ISSUE
    always_comb begin
        HSEL1       = hsel_q;
        rd_en_rom   = hsel_q;
        address_rom = addr_rom_q;
        rsp_valid   = rsp_valid_q;
        rsp_id      = rsp_id_q;
        rsp_data    = rsp_data_q;
        rsp_err     = rsp_err_q;
        busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a small registered ROM model behind it.
module tb_rom_fetch_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              req0_ready, req1_ready;
    logic              rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              HSEL1, rd_en_rom, busy;
    logic [ADDR_W-1:0] address_rom;
    logic [DATA_W-1:0] instruction;

    int checks = 0;
    int failures = 0;
    int hsel_cycles = 0;
    int hsel_before;

    logic [DATA_W-1:0] rom [8];

    rom_fetch_arbiter #(.ROM_DEPTH(5), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .HSEL1(HSEL1), .rd_en_rom(rd_en_rom),
        .address_rom(address_rom), .instruction(instruction), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        rom[0] = 32'h002081b3;
        rom[1] = 32'h40218233;
        rom[2] = 32'h0020c2b3;
        rom[3] = 32'h0020e333;
        rom[4] = 32'h0020f3b3;
        rom[5] = 32'hdeadbeef;
        rom[6] = 32'hdeadbeef;
        rom[7] = 32'hdeadbeef;
        instruction = '0;
    end

    always @(posedge clk) begin
        if (HSEL1 && rd_en_rom) instruction <= rom[address_rom[4:2]];
        if (HSEL1) hsel_cycles <= hsel_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_hsel"}, 64'(HSEL1), 64'd0);
        check({tag, "_rd_en"}, 64'(rd_en_rom), 64'd0);
        check({tag, "_addr_rom"}, 64'(address_rom), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 1'b0; req0_addr = '0;
        req1_valid = 1'b0; req1_addr = '0;
        rsp_ready = 1'b1;

        // reset state
        do_reset();
        check_quiet("rst");
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);

        // single legal fetch from req0
        req0_valid = 1'b1; req0_addr = 32'h0;
        #1;
        check("t1_ready0", 64'(req0_ready), 64'd1);
        check("t1_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        check("t1_issue_hsel", 64'(HSEL1), 64'd1);
        check("t1_issue_rden", 64'(rd_en_rom), 64'd1);
        check("t1_issue_addr", 64'(address_rom), 64'h0);
        check("t1_issue_busy", 64'(busy), 64'd1);
        check("t1_issue_rspv", 64'(rsp_valid), 64'd0);
        tick();
        check("t1_cap_hsel", 64'(HSEL1), 64'd0);
        check("t1_cap_rspv", 64'(rsp_valid), 64'd0);
        tick();
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_id", 64'(rsp_id), 64'd0);
        check("t1_rsp_data", 64'(rsp_data), 64'h002081b3);
        check("t1_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        check("t1_done_rspv", 64'(rsp_valid), 64'd0);
        check("t1_done_busy", 64'(busy), 64'd0);

        // both requesters continuously valid: strict alternation
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h4;
        req1_valid = 1'b1; req1_addr = 32'h8;
        rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            check($sformatf("t2_g%0d_ready0", g), 64'(req0_ready), (g % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("t2_g%0d_ready1", g), 64'(req1_ready), (g % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            check($sformatf("t2_g%0d_issue", g), 64'(HSEL1), 64'd1);
            check($sformatf("t2_g%0d_addr", g), 64'(address_rom), (g % 2 == 0) ? 64'h4 : 64'h8);
            tick();
            check($sformatf("t2_g%0d_hsel_off", g), 64'(HSEL1), 64'd0);
            tick();
            check($sformatf("t2_g%0d_rspv", g), 64'(rsp_valid), 64'd1);
            check($sformatf("t2_g%0d_id", g), 64'(rsp_id), 64'(g % 2));
            check($sformatf("t2_g%0d_data", g), 64'(rsp_data),
                  (g % 2 == 0) ? 64'h40218233 : 64'h0020c2b3);
            check($sformatf("t2_g%0d_hsel_rsp", g), 64'(HSEL1), 64'd0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t2_idle_busy", 64'(busy), 64'd0);

        // out-of-range then misaligned from req1
        hsel_before = hsel_cycles;
        req1_valid = 1'b1; req1_addr = 32'h14;
        #1;
        check("t3a_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("t3a_rspv", 64'(rsp_valid), 64'd1);
        check("t3a_err", 64'(rsp_err), 64'd1);
        check("t3a_data", 64'(rsp_data), 64'd0);
        check("t3a_id", 64'(rsp_id), 64'd1);
        check("t3a_hsel", 64'(HSEL1), 64'd0);
        tick();
        check("t3a_done", 64'(rsp_valid), 64'd0);
        req1_valid = 1'b1; req1_addr = 32'h6;
        #1;
        check("t3b_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("t3b_rspv", 64'(rsp_valid), 64'd1);
        check("t3b_err", 64'(rsp_err), 64'd1);
        check("t3b_data", 64'(rsp_data), 64'd0);
        tick();
        check("t3b_done", 64'(rsp_valid), 64'd0);
        check("t3_no_hsel", 64'(hsel_cycles), 64'(hsel_before));

        // back-pressure: response must hold while rsp_ready is low
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_addr = 32'h0;
        #1;
        check("t4_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold%0d_rspv", i), 64'(rsp_valid), 64'd1);
            check($sformatf("t4_hold%0d_data", i), 64'(rsp_data), 64'h0020f3b3);
            check($sformatf("t4_hold%0d_id", i), 64'(rsp_id), 64'd0);
            check($sformatf("t4_hold%0d_ready1", i), 64'(req1_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        check("t4_final_rspv", 64'(rsp_valid), 64'd1);
        tick();
        check("t4_done_rspv", 64'(rsp_valid), 64'd0);
        check("t4_done_busy", 64'(busy), 64'd0);

        // reset asserted during CAPTURE drops the read and restores rr_ptr
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h8;
        tick();
        req0_valid = 1'b0;
        tick();
        check("t5_in_capture", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        check_quiet("t5_rst");
        check("t5_rst_data", 64'(rsp_data), 64'd0);
        check("t5_rst_ready0", 64'(req0_ready), 64'd0);
        reset = 1'b1;
        tick();
        check("t5_after_rspv", 64'(rsp_valid), 64'd0);
        req0_valid = 1'b1; req0_addr = 32'h0;
        req1_valid = 1'b1; req1_addr = 32'h4;
        #1;
        check("t5_rr_ready0", 64'(req0_ready), 64'd1);
        check("t5_rr_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        check("t5_rr_id", 64'(rsp_id), 64'd0);
        check("t5_rr_data", 64'(rsp_data), 64'h002081b3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares the single-port instruction ROM (HSEL1 / rd_en_rom / address_rom / instruction interface) between two requesters.
  - Requester 0: core instruction-fetch unit.
  - Requester 1: debug/AHB read port.
- Round-robin arbitration, sequences each ROM read through a 4-state FSM, checks address range/alignment, returns the fetched word on one shared response channel tagged with requester id.
- Sits between the fetch/debug masters and the ROM slave, inside the AHB slave decode region for HSEL1.

Parameters:
ROM_DEPTH, 5, number of 32-bit words in the ROM; legal byte addresses 0 .. ROM_DEPTH*4-4
ADDR_W, 32, request/ROM address width
DATA_W, 32, instruction word width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
req0_valid  input  1  fetch unit read request
req0_addr  input  ADDR_W  fetch byte address
req0_ready  output  1  request 0 accepted this cycle
req1_valid  input  1  debug port read request
req1_addr  input  ADDR_W  debug byte address
req1_ready  output  1  request 1 accepted this cycle
rsp_valid  output  1  response available
rsp_id  output  1  requester owning the response (0/1)
rsp_data  output  DATA_W  fetched word (0 on error)
rsp_err  output  1  address out of range or misaligned
rsp_ready  input  1  consumer accepts response
HSEL1  output  1  ROM slave select
rd_en_rom  output  1  ROM read enable
address_rom  output  ADDR_W  ROM byte address
instruction  input  DATA_W  ROM read data, registered inside ROM (1-cycle)
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; rr_ptr=0 (req0 favoured); all outputs 0. Applies mid-transaction: in-flight read is dropped, no response issued.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - reqN_ready is combinational, asserted only for the granted requester: if one valid, grant it; if both valid, grant the one equal to rr_ptr.
  - On accept, latch addr and id; rr_ptr <= ~granted id.
  - Range check: addr[1:0]!=0 or addr >= ROM_DEPTH*4 -> error. Latch rsp_err=1, rsp_data=0, go directly to RESP.
  - Legal address -> ISSUE.
  - No valid -> stay in IDLE; ready=0.
- ISSUE (1 cycle): HSEL1=1, rd_en_rom=1, address_rom=latched addr, all registered outputs. -> CAPTURE.
- CAPTURE (1 cycle): HSEL1=rd_en_rom=0, address_rom=0. Register instruction into rsp_data, rsp_err=0. -> RESP.
- RESP: rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_ready==1 at a clk edge, then -> IDLE.
- Outputs in IDLE/RESP: HSEL1=rd_en_rom=0, address_rom=0.
- Latency, legal read:
  - accept edge T; ISSUE cycle T+1; CAPTURE T+2; rsp_valid high from T+3.
  - Max throughput: 1 read per 4 cycles with rsp_ready tied high.
- Latency, error: rsp_valid from T+1; no ROM access.
- Requests arriving in non-IDLE states are not accepted (ready=0); requesters hold valid/addr until ready.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Only one outstanding ROM read at any time; HSEL1 is never asserted outside ISSUE.
- rsp_valid deasserts the cycle after the handshake edge; a new grant may occur in that same IDLE cycle.

Test Plan:
- Reset, then req0 addr 0x0 -> HSEL1=rd_en_rom=1, address_rom=0 exactly one cycle; rsp_valid 3 cycles after accept, rsp_id=0, rsp_data=0x002081b3, rsp_err=0.
- req0 and req1 both valid continuously, addrs 0x4/0x8, rsp_ready=1 -> grants 0,1,0,1; rsp_data alternates 0x40218233/0x0020c2b3; HSEL1 never high 2 consecutive cycles.
- req1 addr 0x14 (out of range), then addr 0x6 (misaligned) -> each: rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, no HSEL1 pulse.
- req0 addr 0x10, rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data=0x0020f3b3 stable all 5 cycles, req1_ready=0 throughout; completes on rsp_ready=1.
- reset driven 0 during CAPTURE -> next cycle all outputs 0, state IDLE, no rsp_valid; next req1 with req0 also valid is granted to req0 (rr_ptr reset).
